// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//   This block checks a received word stream against the DW-bit XNOR LFSR
//   sequence, where the sequence advances by one bit shift per word. The
//   checker seeds itself from the incoming data, predicts each following word,
//   and declares lock after LOCK_CNT consecutive correct predictions. Once
//   locked it keeps advancing its own prediction, so an isolated bad word does
//   not disturb the words that follow. UNLOCK_ERR consecutive misses drop the
//   checker back to hunting.
//
// Ports
//   i_sysclk    system clock
//   i_areset    asynchronous, active-high reset
//   i_valid     qualifies i_data for one cycle
//   i_data      received word
//   i_clear     synchronous clear of both counters
//   o_locked    high while the checker is locked
//   o_err       one-cycle pulse when a valid word mismatches while locked
//   o_expected  prediction used for the last compared word
//   o_word_cnt  valid words compared while locked (saturating)
//   o_err_cnt   mismatches counted while locked (saturating)
//
// state  | meaning
// -------+---------------------------------------------------------------
// HUNT   | waiting for a usable (not all-ones) seed word
// VERIFY | seeded; counting consecutive correct predictions toward lock
// LOCKED | locked; flywheeling the prediction and counting words and errors
// -----------------------------------------------------------------------------
module lfsr_checker #(
   parameter int DW         = 8,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_ERR = 4
) (
   input  logic          i_sysclk,
   input  logic          i_areset,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   input  logic          i_clear,
   output logic          o_locked,
   output logic          o_err,
   output logic [DW-1:0] o_expected,
   output logic [31:0]   o_word_cnt,
   output logic [31:0]   o_err_cnt
);

   // Tap masks are 0-based bit positions of the 1-based taps.
   // 4:{4,3}  8:{8,6,5,4}  16:{16,15,13,4}  32:{32,22,2,1}
   localparam logic [31:0] TAP32 = (DW == 4)  ? 32'h0000_000C :
                                   (DW == 8)  ? 32'h0000_00B8 :
                                   (DW == 16) ? 32'h0000_D008 :
                                                32'h8020_0003;
   localparam logic [DW-1:0] TAP_MASK  = TAP32[DW-1:0];
   localparam logic [7:0]    LOCK_W    = 8'(LOCK_CNT);
   localparam logic [7:0]    UNLOCK_W  = 8'(UNLOCK_ERR);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] base_q, base_d;
   logic [7:0]    match_q, match_d;
   logic [7:0]    miss_q, miss_d;
   logic          err_q, err_d;
   logic [DW-1:0] exp_q, exp_d;
   logic [31:0]   word_cnt_q, word_cnt_d;
   logic [31:0]   err_cnt_q, err_cnt_d;

   logic [DW-1:0] pred;
   logic          hit;
   logic          all_ones;
   logic [31:0]   word_inc;
   logic [31:0]   err_inc;

   function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
      return {x[DW-2:0], ~(^(x & TAP_MASK))};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   always_comb begin
      pred       = lfsr_next(base_q);
      hit        = (i_data == pred);
      all_ones   = &i_data;
      state_d    = state_q;
      base_d     = base_q;
      match_d    = match_q;
      miss_d     = miss_q;
      err_d      = 1'b0;
      exp_d      = exp_q;
      word_inc   = word_cnt_q;
      err_inc    = err_cnt_q;

      if (i_valid) begin
         case (state_q)
            HUNT: begin
               // All-ones is the XNOR lockup word and can never seed a sequence.
               if (!all_ones) begin
                  base_d  = i_data;
                  match_d = 8'd0;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               exp_d  = pred;
               base_d = i_data;
               if (hit) begin
                  match_d = match_q + 8'd1;
                  if (match_d == LOCK_W) begin
                     miss_d  = 8'd0;
                     state_d = LOCKED;
                  end
               end else begin
                  match_d = 8'd0;
                  if (all_ones) begin
                     state_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               exp_d    = pred;
               // Flywheel: advance on our own prediction, never on received data.
               base_d   = pred;
               word_inc = sat_inc(word_cnt_q);
               if (hit) begin
                  miss_d = 8'd0;
               end else begin
                  miss_d  = miss_q + 8'd1;
                  err_d   = 1'b1;
                  err_inc = sat_inc(err_cnt_q);
                  if (miss_d == UNLOCK_W) begin
                     state_d = HUNT;
                  end
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end

      word_cnt_d = i_clear ? 32'd0 : word_inc;
      err_cnt_d  = i_clear ? 32'd0 : err_inc;
   end

   always_ff @(posedge i_sysclk or posedge i_areset) begin
      if (i_areset) begin
         state_q    <= HUNT;
         base_q     <= '0;
         match_q    <= 8'd0;
         miss_q     <= 8'd0;
         err_q      <= 1'b0;
         exp_q      <= '0;
         word_cnt_q <= 32'd0;
         err_cnt_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         err_q      <= err_d;
         exp_q      <= exp_d;
         word_cnt_q <= word_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign o_locked   = (state_q == LOCKED);
   assign o_err      = err_q;
   assign o_expected = exp_q;
   assign o_word_cnt = word_cnt_q;
   assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//   Drives lfsr_checker (DW=8, LOCK_CNT=4, UNLOCK_ERR=4) with directed and
//   randomized word streams and compares every output after every clock against
//   a behavioural model of the lock/flywheel rules.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

   localparam int DW         = 8;
   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_ERR = 4;

   logic          i_sysclk;
   logic          i_areset;
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          i_clear;
   logic          o_locked;
   logic          o_err;
   logic [DW-1:0] o_expected;
   logic [31:0]   o_word_cnt;
   logic [31:0]   o_err_cnt;

   lfsr_checker #(
      .DW         (DW),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_ERR (UNLOCK_ERR)
   ) dut (
      .i_sysclk   (i_sysclk),
      .i_areset   (i_areset),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .i_clear    (i_clear),
      .o_locked   (o_locked),
      .o_err      (o_err),
      .o_expected (o_expected),
      .o_word_cnt (o_word_cnt),
      .o_err_cnt  (o_err_cnt)
   );

   initial i_sysclk = 1'b0;
   always #5 i_sysclk = ~i_sysclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the sequence rule from tap positions, plus lock rules.
   function automatic logic [DW-1:0] prbs_next(input logic [DW-1:0] x);
      int taps[4] = '{8, 6, 5, 4};
      logic fb = 1'b1;
      foreach (taps[k]) fb = fb ^ x[taps[k]-1];
      return {x[DW-2:0], fb};
   endfunction

   string         m_mode;
   logic [DW-1:0] m_base;
   int            m_match;
   int            m_miss;
   logic          m_err;
   logic [DW-1:0] m_exp;
   longint        m_wc;
   longint        m_ec;

   task automatic m_reset();
      m_mode  = "hunt";
      m_base  = '0;
      m_match = 0;
      m_miss  = 0;
      m_err   = 1'b0;
      m_exp   = '0;
      m_wc    = 0;
      m_ec    = 0;
   endtask

   task automatic m_update(input logic v, input logic [DW-1:0] d, input logic clr);
      logic [DW-1:0] p;
      p     = prbs_next(m_base);
      m_err = 1'b0;
      if (v) begin
         if (m_mode == "hunt") begin
            if (d != 8'hFF) begin
               m_base  = d;
               m_match = 0;
               m_mode  = "verify";
            end
         end else if (m_mode == "verify") begin
            m_exp  = p;
            m_base = d;
            if (d == p) begin
               m_match++;
               if (m_match == LOCK_CNT) begin
                  m_mode = "locked";
                  m_miss = 0;
               end
            end else begin
               m_match = 0;
               if (d == 8'hFF) m_mode = "hunt";
            end
         end else begin
            m_exp  = p;
            m_base = p;
            if (m_wc < 64'hFFFF_FFFF) m_wc++;
            if (d == p) m_miss = 0;
            else begin
               m_miss++;
               m_err = 1'b1;
               if (m_ec < 64'hFFFF_FFFF) m_ec++;
               if (m_miss == UNLOCK_ERR) m_mode = "hunt";
            end
         end
      end
      if (clr) begin
         m_wc = 0;
         m_ec = 0;
      end
   endtask

   task automatic check_all();
      check_eq("locked",   o_locked,   (m_mode == "locked"));
      check_eq("err",      o_err,      m_err);
      check_eq("expected", o_expected, m_exp);
      check_eq("word_cnt", o_word_cnt, m_wc);
      check_eq("err_cnt",  o_err_cnt,  m_ec);
   endtask

   // Inputs are applied 1 time unit after a rising edge, sampled on the next
   // rising edge, and outputs are checked 1 time unit after that edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic clr);
      i_valid = v;
      i_data  = d;
      i_clear = clr;
      @(posedge i_sysclk);
      m_update(v, d, clr);
      #1;
      check_all();
      i_valid = 1'b0;
      i_clear = 1'b0;
   endtask

   task automatic feed_seed_seq();
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h03, 1'b0);
      step(1'b1, 8'h07, 1'b0);
      step(1'b1, 8'h0F, 1'b0);
      check_eq("not_locked_4th", o_locked, 1'b0);
      step(1'b1, 8'h1E, 1'b0);
      check_eq("locked_5th", o_locked, 1'b1);
   endtask

   logic [DW-1:0] gen;
   logic [DW-1:0] d;
   int            errs_seen;

   initial begin
      i_areset = 1'b1;
      i_valid  = 1'b0;
      i_data   = '0;
      i_clear  = 1'b0;
      m_reset();
      repeat (3) @(posedge i_sysclk);
      #1;
      check_all();
      i_areset = 1'b0;

      // Lock from the seed sequence; the locking word is not counted.
      feed_seed_seq();
      check_eq("wc_at_lock", o_word_cnt, 32'd0);

      // 100 correct words with sprinkled idle cycles.
      gen = 8'h1E;
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
         gen = prbs_next(gen);
         step(1'b1, gen, 1'b0);
         check_eq("exp_tracks", o_expected, gen);
      end
      check_eq("wc_100", o_word_cnt, 32'd100);
      check_eq("ec_0", o_err_cnt, 32'd0);

      // Single corrupted word; flywheel keeps the following word matching.
      gen = prbs_next(gen);
      step(1'b1, gen ^ 8'h10, 1'b0);
      check_eq("single_err_pulse", o_err, 1'b1);
      gen = prbs_next(gen);
      step(1'b1, gen, 1'b0);
      check_eq("after_err_clean", o_err, 1'b0);
      check_eq("ec_1", o_err_cnt, 32'd1);
      check_eq("lock_held", o_locked, 1'b1);

      // Four consecutive bad words force unlock; counters cleared first.
      step(1'b0, 8'h00, 1'b1);
      errs_seen = 0;
      for (int i = 0; i < 4; i++) begin
         gen = prbs_next(gen);
         step(1'b1, gen ^ 8'h10, 1'b0);
         if (o_err) errs_seen++;
      end
      check_eq("err_pulses_4", 64'(errs_seen), 64'd4);
      check_eq("ec_4", o_err_cnt, 32'd4);
      check_eq("unlocked", o_locked, 1'b0);
      feed_seed_seq();

      // Clear and mismatch in the same cycle.
      step(1'b1, prbs_next(8'h1E) ^ 8'h01, 1'b1);
      check_eq("clr_wc", o_word_cnt, 32'd0);
      check_eq("clr_ec", o_err_cnt, 32'd0);
      check_eq("clr_err_pulse", o_err, 1'b1);

      // Asynchronous reset with no clock edge.
      i_areset = 1'b1;
      #1;
      m_reset();
      check_all();
      #2;
      i_areset = 1'b0;

      // All-ones stays in HUNT; then reseed in VERIFY.
      for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h05, 1'b0);
      check_eq("reseed_exp", o_expected, 8'h03);
      check_eq("reseed_noerr", o_err, 1'b0);
      gen = 8'h05;
      for (int i = 0; i < 4; i++) begin
         gen = prbs_next(gen);
         step(1'b1, gen, 1'b0);
      end
      check_eq("relock_after_reseed", o_locked, 1'b1);

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic clr;
         r   = $urandom_range(0, 99);
         clr = ($urandom_range(0, 49) == 0);
         if (i % 300 == 150) begin
            for (int k = 0; k < 5; k++) begin
               gen = prbs_next(gen);
               step(1'b1, gen ^ 8'(1 << $urandom_range(0, 7)), 1'b0);
            end
         end else if (r < 15) begin
            step(1'b0, 8'($urandom), clr);
         end else begin
            gen = prbs_next(gen);
            d   = gen;
            if (r < 20) d = gen ^ 8'($urandom_range(1, 255));
            else if (r == 20) d = 8'hFF;
            else if (r == 21) begin
               gen = 8'($urandom_range(0, 254));
               d   = gen;
            end
            step(1'b1, d, clr);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
